alarm_unit: RTL and testbench

- Alarm stage directly downstream of the hour/min/sec counter block.
- Consumes the live hour, min and sec counts and holds a user-settable alarm time (hour:min).
- Detects the moment the live time reaches alarm_hour:alarm_min:00 and rings a beeping square-wave buzzer until the user stops it or a timeout expires.
- Also exports the alarm time so the display path can show it in alarm-setup mode.

---
 rtl/alarm_unit_pkg.sv | 27 ++
 rtl/alarm_tone.sv | 36 +++
 rtl/alarm_unit.sv | 126 ++++++++++++
 tb/tb_alarm_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_unit_pkg.sv
// Shared types and constants for the alarm stage: state encoding, time-field limits
// and the wrapping increment used by the alarm-set logic.
package alarm_unit_pkg;

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned TONE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RING  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] MAX_SEC  = CNT_W'(59);
  localparam logic [CNT_W-1:0] MAX_MIN  = CNT_W'(59);
  localparam logic [CNT_W-1:0] MAX_HOUR = CNT_W'(23);

  localparam logic POS_MIN  = 1'b0;
  localparam logic POS_HOUR = 1'b1;

  // Increment a time field, wrapping to zero after max (no carry out).
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] max);
    return (v >= max) ? '0 : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/alarm_tone.sv
// Square-wave tone generator: while enabled, toggles the output every TONE_HALF clocks;
// when disabled the counter and output are held at zero.
module alarm_tone
  import alarm_unit_pkg::*;
#(
  parameter int unsigned TONE_HALF = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_buzz
);

  localparam logic [TONE_W-1:0] LAST = TONE_W'(TONE_HALF - 1);

  logic [TONE_W-1:0] tone_cnt_q;
  logic              buzz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      buzz_q     <= 1'b0;
    end else if (!i_en) begin
      tone_cnt_q <= '0;
      buzz_q     <= 1'b0;
    end else if (tone_cnt_q >= LAST) begin
      tone_cnt_q <= '0;
      buzz_q     <= ~buzz_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + TONE_W'(1);
    end
  end

  assign o_buzz = buzz_q;

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage behind the hour/min/sec counters: samples the live time, holds a settable
// alarm time, and rings a beeping buzzer on match until stopped, disabled or timed out.
module alarm_unit
  import alarm_unit_pkg::*;
#(
  parameter int unsigned TONE_HALF = 25000,
  parameter int unsigned RING_SEC  = 30,
  parameter int unsigned RST_HOUR  = 7,
  parameter int unsigned RST_MIN   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_sec,
  input  logic [CNT_W-1:0] i_min,
  input  logic [CNT_W-1:0] i_hour,
  input  logic             i_alarm_en,
  input  logic             i_set_pos,
  input  logic             i_set_inc,
  input  logic             i_stop,
  output logic [CNT_W-1:0] o_alarm_hour,
  output logic [CNT_W-1:0] o_alarm_min,
  output logic             o_ringing,
  output logic             o_buzz,
  output logic [1:0]       o_state
);

  localparam int unsigned RING_W = ($clog2(RING_SEC + 1) > 8) ? $clog2(RING_SEC + 1) : 8;
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);

  state_e             state_q, state_d;
  logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0]   alarm_hour_q, alarm_hour_d;
  logic [CNT_W-1:0]   alarm_min_q, alarm_min_d;
  logic [CNT_W-1:0]   sec_d1_q, sec_d2_q, min_d1_q, hour_d1_q;
  logic               ringing_q;
  logic               tick_c, match_c, beep_on_c;

  // Live counts arrive from the ripple-clock domain; second edge is found on the d1/d2 pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_d1_q  <= '0;
      sec_d2_q  <= '0;
      min_d1_q  <= '0;
      hour_d1_q <= '0;
    end else begin
      sec_d1_q  <= i_sec;
      sec_d2_q  <= sec_d1_q;
      min_d1_q  <= i_min;
      hour_d1_q <= i_hour;
    end
  end

  assign tick_c  = (sec_d1_q != sec_d2_q);
  assign match_c = tick_c && (sec_d1_q == '0) &&
                   (min_d1_q == alarm_min_q) && (hour_d1_q == alarm_hour_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ring_cnt_q   <= '0;
      alarm_hour_q <= CNT_W'(RST_HOUR);
      alarm_min_q  <= CNT_W'(RST_MIN);
      ringing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      ringing_q    <= (state_d == ST_RING);
    end
  end

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;

    if (!i_alarm_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: begin
          if (!i_stop && match_c) begin
            state_d    = ST_RING;
            ring_cnt_d = '0;
          end
        end
        ST_RING: begin
          if (i_stop) begin
            state_d = ST_ARMED;
          end else if (tick_c) begin
            if (ring_cnt_q == RING_LAST) state_d = ST_ARMED;
            else                         ring_cnt_d = ring_cnt_q + RING_W'(1);
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end

    // Alarm time is frozen while ringing so a stray press cannot move a live alarm.
    if (i_set_inc && (state_q != ST_RING)) begin
      if (i_set_pos == POS_HOUR) alarm_hour_d = wrap_inc(alarm_hour_q, MAX_HOUR);
      else                       alarm_min_d  = wrap_inc(alarm_min_q, MAX_MIN);
    end
  end

  // Tone runs only in even ring seconds; gating on next state silences it on the leaving edge.
  assign beep_on_c = (state_q == ST_RING) && (state_d == ST_RING) && !ring_cnt_d[0];

  alarm_tone #(
    .TONE_HALF (TONE_HALF)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (beep_on_c),
    .o_buzz (o_buzz)
  );

  assign o_alarm_hour = alarm_hour_q;
  assign o_alarm_min  = alarm_min_q;
  assign o_ringing    = ringing_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit with TONE_HALF=4, RING_SEC=3: set, match, tone cadence,
// stop, simultaneous events, enable drop and asynchronous reset during ringing.
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] i_sec, i_min, i_hour;
  logic       i_alarm_en, i_set_pos, i_set_inc, i_stop;
  logic [5:0] o_alarm_hour, o_alarm_min;
  logic       o_ringing, o_buzz;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;
  int tog;

  alarm_unit #(
    .TONE_HALF (4),
    .RING_SEC  (3),
    .RST_HOUR  (7),
    .RST_MIN   (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sec        (i_sec),
    .i_min        (i_min),
    .i_hour       (i_hour),
    .i_alarm_en   (i_alarm_en),
    .i_set_pos    (i_set_pos),
    .i_set_inc    (i_set_inc),
    .i_stop       (i_stop),
    .o_alarm_hour (o_alarm_hour),
    .o_alarm_min  (o_alarm_min),
    .o_ringing    (o_ringing),
    .o_buzz       (o_buzz),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_live(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    i_hour = h;
    i_min  = m;
    i_sec  = s;
  endtask

  task automatic pulse_inc(input logic pos, input int n);
    i_set_pos = pos;
    repeat (n) begin
      i_set_inc = 1'b1;
      step(1);
      i_set_inc = 1'b0;
      step(1);
    end
  endtask

  task automatic count_toggles(input int n, output int t);
    logic prev;
    t    = 0;
    prev = o_buzz;
    repeat (n) begin
      step(1);
      if (o_buzz !== prev) t++;
      prev = o_buzz;
    end
  endtask

  // Walk live time from ph:pm:59 into h:m:00; ringing is expected two edges later.
  task automatic ring_up(input logic [5:0] ph, input logic [5:0] pm,
                         input logic [5:0] h, input logic [5:0] m);
    set_live(ph, pm, 6'd59);
    step(3);
    set_live(h, m, 6'd0);
    step(2);
  endtask

  initial begin
    rst_n = 1'b0;
    i_alarm_en = 1'b0; i_set_pos = 1'b0; i_set_inc = 1'b0; i_stop = 1'b0;
    set_live(6'd12, 6'd30, 6'd15);
    step(3);
    rst_n = 1'b1;
    step(2);
    check("rst_hour",  o_alarm_hour, 7);
    check("rst_min",   o_alarm_min, 0);
    check("rst_state", o_state, 0);
    check("rst_buzz",  o_buzz, 0);

    i_alarm_en = 1'b1;
    step(1);
    check("arm_state", o_state, 1);

    pulse_inc(1'b0, 61);
    check("set_min_wrap", o_alarm_min, 1);
    check("set_min_hour_untouched", o_alarm_hour, 7);
    pulse_inc(1'b1, 17);
    check("set_hour_wrap", o_alarm_hour, 0);
    check("set_hour_min_untouched", o_alarm_min, 1);

    // Back to 07:00 via reset.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(2);
    check("rearm_state", o_state, 1);
    check("rearm_hour", o_alarm_hour, 7);

    // Match latency and tone cadence.
    set_live(6'd6, 6'd59, 6'd59);
    step(3);
    set_live(6'd7, 6'd0, 6'd0);
    step(1);
    check("match_n_not_ringing", o_ringing, 0);
    step(1);
    check("match_n1_ringing", o_ringing, 1);
    check("match_state_ring", o_state, 2);
    check("ring_buzz_start", o_buzz, 0);
    count_toggles(12, tog);
    check("sec0_toggles", tog, 3);
    i_sec = 6'd1;
    step(2);
    check("sec1_buzz_off", o_buzz, 0);
    count_toggles(12, tog);
    check("sec1_toggles", tog, 0);
    check("sec1_state", o_state, 2);
    i_sec = 6'd2;
    step(2);
    count_toggles(12, tog);
    check("sec2_toggles", tog, 3);
    check("sec2_state", o_state, 2);
    i_sec = 6'd3;
    step(2);
    check("timeout_state", o_state, 1);
    check("timeout_ringing", o_ringing, 0);
    check("timeout_buzz", o_buzz, 0);

    // Stop during ring, then no re-ring within the same minute.
    ring_up(6'd6, 6'd59, 6'd7, 6'd0);
    check("ring2_state", o_state, 2);
    step(4);
    check("ring2_buzz_on", o_buzz, 1);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    check("stop_state", o_state, 1);
    check("stop_buzz", o_buzz, 0);
    for (int s = 1; s <= 5; s++) begin
      i_sec = 6'(s);
      step(3);
      check("no_reretrigger_state", o_state, 1);
    end

    // Stop in the match cycle: never rings.
    set_live(6'd6, 6'd59, 6'd59);
    step(3);
    set_live(6'd7, 6'd0, 6'd0);
    step(1);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    check("stop_match_state", o_state, 1);
    step(3);
    check("stop_match_later", o_ringing, 0);

    // Enable dropped mid-ring.
    ring_up(6'd6, 6'd59, 6'd7, 6'd0);
    step(4);
    check("ring3_buzz_on", o_buzz, 1);
    i_alarm_en = 1'b0;
    step(1);
    check("en_drop_state", o_state, 0);
    check("en_drop_buzz", o_buzz, 0);
    check("en_drop_ringing", o_ringing, 0);
    i_alarm_en = 1'b1;
    step(1);
    check("en_back_state", o_state, 1);

    // Move alarm to 07:01, ring, try to set during ring, then async reset mid-ring.
    pulse_inc(1'b0, 1);
    check("set_0701", o_alarm_min, 1);
    ring_up(6'd7, 6'd0, 6'd7, 6'd1);
    check("ring4_state", o_state, 2);
    pulse_inc(1'b0, 1);
    pulse_inc(1'b1, 1);
    check("ring_set_min_frozen", o_alarm_min, 1);
    check("ring_set_hour_frozen", o_alarm_hour, 7);
    check("ring4_still", o_state, 2);
    step(1);
    check("ring4_buzz_on", o_buzz, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", o_state, 0);
    check("async_ringing", o_ringing, 0);
    check("async_buzz", o_buzz, 0);
    check("async_min", o_alarm_min, 0);
    check("async_hour", o_alarm_hour, 7);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("post_reset_state", o_state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
